// File: rtl/io_input_responder.sv
// rtl/io_input_responder.sv - responder for the core's input instruction: debounced confirm key, switch capture
//
// Purpose:
//   When the core executes an input instruction, it raises request and is held
//   by stall. This block waits for the confirm key to be released, then pressed.
//   Both the release and the press must be stable for DEBOUNCE_CYCLES samples.
//   On the press it captures the 18 switches as a sign-extended word and
//   releases the core with a one-cycle done pulse. A cancel key ends the
//   instruction at once with a zero word.
//
// Ports:
//   clock     system clock; all state changes on the rising edge
//   reset     asynchronous, active-high
//   request   level from the core; high while the input instruction is pending
//   switches  raw board switches sw17..sw0 (asynchronous)
//   key0      raw confirm key, active-low (asynchronous)
//   key1      raw cancel key, active-low (asynchronous)
//   stall     holds PC and register write while the input is pending
//   dataOut   captured word; valid from the done cycle until the next capture
//   done      one-cycle completion pulse
//   waiting   operator prompt LED; high while armed or counting a press

module io_input_responder #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int COUNT_WIDTH     = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        request,
   input  logic [17:0] switches,
   input  logic        key0,
   input  logic        key1,
   output logic        stall,
   output logic [31:0] dataOut,
   output logic        done,
   output logic        waiting
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARM   = 2'd1,
      S_PRESS = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] DEB = COUNT_WIDTH'(DEBOUNCE_CYCLES);

   // Two-flop synchronizers. The keys reset to 1 so that they read as released.
   logic        key0_s1_q, key0_s2_q;
   logic        key1_s1_q, key1_s2_q;
   logic [17:0] sw_s1_q, sw_s2_q;

   state_t                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [31:0]            data_q, data_d;
   logic                   done_q, done_d;
   logic                   waiting_q, waiting_d;

   // The counter saturates at DEB. It is cleared on every state change, so
   // saturation only guards against wrap.
   logic [COUNT_WIDTH-1:0] cnt_inc;
   assign cnt_inc = (cnt_q >= DEB) ? DEB : cnt_q + COUNT_WIDTH'(1);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         key0_s1_q <= 1'b1;
         key0_s2_q <= 1'b1;
         key1_s1_q <= 1'b1;
         key1_s2_q <= 1'b1;
         sw_s1_q   <= 18'd0;
         sw_s2_q   <= 18'd0;
      end else begin
         key0_s1_q <= key0;
         key0_s2_q <= key0_s1_q;
         key1_s1_q <= key1;
         key1_s2_q <= key1_s1_q;
         sw_s1_q   <= switches;
         sw_s2_q   <= sw_s1_q;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         data_q    <= 32'd0;
         done_q    <= 1'b0;
         waiting_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         done_q    <= done_d;
         waiting_q <= waiting_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (request) state_d = S_ARM;
         end
         S_ARM: begin
            // The key must be seen released before a press can count. This
            // keeps a key still held from the last input from satisfying
            // this one.
            if (!request) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (!key1_s2_q) begin
               data_d  = 32'd0;
               state_d = S_DONE;
               cnt_d   = '0;
            end else if (key0_s2_q) begin
               if (cnt_inc == DEB) begin
                  state_d = S_PRESS;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end else begin
               cnt_d = '0;
            end
         end
         S_PRESS: begin
            // Cancel is checked before press completion, so cancel wins when
            // both happen in the same cycle.
            if (!request) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (!key1_s2_q) begin
               data_d  = 32'd0;
               state_d = S_DONE;
               cnt_d   = '0;
            end else if (!key0_s2_q) begin
               if (cnt_inc == DEB) begin
                  data_d  = {{14{sw_s2_q[17]}}, sw_s2_q};
                  state_d = S_DONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end else begin
               cnt_d = '0;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // The indicator outputs are decoded from the next state and then
   // registered. They therefore line up exactly with the state register and
   // cannot glitch.
   always_comb begin
      done_d    = (state_d == S_DONE);
      waiting_d = (state_d == S_ARM) || (state_d == S_PRESS);
   end

   assign stall   = request & (state_q != S_DONE) & ~reset;
   assign dataOut = data_q;
   assign done    = done_q;
   assign waiting = waiting_q;

endmodule

// File: tb/tb_io_input_responder.sv
// tb/tb_io_input_responder.sv - scoreboard bench for io_input_responder with randomized operator sequences

module tb_io_input_responder;

   localparam int D = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        request;
   logic [17:0] switches;
   logic        key0;
   logic        key1;
   logic        stall;
   logic [31:0] dataOut;
   logic        done;
   logic        waiting;

   int n_checks   = 0;
   int n_pass     = 0;
   int n_expected = 0;
   int n_done     = 0;

   logic [31:0] exp_q[$];

   io_input_responder #(.DEBOUNCE_CYCLES(D), .COUNT_WIDTH(16)) dut (
      .clock    (clock),
      .reset    (reset),
      .request  (request),
      .switches (switches),
      .key0     (key0),
      .key1     (key1),
      .stall    (stall),
      .dataOut  (dataOut),
      .done     (done),
      .waiting  (waiting)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference: the switch value read as an 18-bit two's-complement number.
   function automatic logic [31:0] sext(input logic [17:0] s);
      int v;
      v = int'(s);
      if (v >= 32'h20000) v = v - 32'h40000;
      return 32'(v);
   endfunction

   task automatic expect_word(input logic [31:0] w);
      exp_q.push_back(w);
      n_expected++;
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Latency is counted in rising edges after key0 was driven low. The first
   // edge samples the raw key, two edges cover synchronization, and D samples
   // are needed to qualify the press.
   task automatic wait_done(input string name, input bit chk_lat);
      int  k;
      bit  got;
      got = 1'b0;
      for (k = 1; k <= 30; k++) begin
         cyc(1);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_checks++;
         $display("FAIL %s_timeout: got no done expected done within 30 cycles", name);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (chk_lat) begin
         n_checks++;
         if (k >= D + 2 && k <= D + 3) n_pass++;
         else $display("FAIL %s_latency: got %0d expected %0d..%0d", name, k, D + 2, D + 3);
      end
   endtask

   task automatic press(input string name, input logic [17:0] sw, input bit cancel,
                        input int nbounce, input bit keep_req);
      switches = sw;
      request  = 1'b1;
      key0     = 1'b1;
      key1     = 1'b1;
      cyc(8);
      check({name, "_waiting"}, {31'd0, waiting}, 32'd1);
      for (int b = 0; b < nbounce; b++) begin
         key0 = 1'b0;
         cyc($urandom_range(1, D - 1));
         key0 = 1'b1;
         cyc($urandom_range(1, 2));
      end
      if (cancel) begin
         expect_word(32'd0);
         key1 = 1'b0;
         cyc(1);
         key1 = 1'b1;
         wait_done(name, 1'b0);
      end else begin
         expect_word(sext(sw));
         key0 = 1'b0;
         wait_done(name, 1'b1);
      end
      if (!keep_req) request = 1'b0;
      key0 = 1'b1;
      cyc(1);
   endtask

   // Monitor: pops the scoreboard on every done pulse and checks stall each cycle.
   always @(negedge clock) begin
      if (!reset) begin
         check("stall", {31'd0, stall}, {31'd0, request && !done});
         if (done) begin
            n_done++;
            check("done_waiting", {31'd0, waiting}, 32'd0);
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_done: got done with dataOut %h expected no done", dataOut);
            end else begin
               check("dataOut", dataOut, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [17:0] sw;
      reset    = 1'b1;
      request  = 1'b1;
      switches = 18'h3FFFF;
      key0     = 1'b1;
      key1     = 1'b1;
      #1;
      check("rst_dataOut", dataOut, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_waiting", {31'd0, waiting}, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      request = 1'b0;
      cyc(3);
      reset = 1'b0;
      cyc(2);

      press("basic", 18'h00ABC, 1'b0, 0, 1'b0);
      press("signext", 18'h20001, 1'b0, 0, 1'b0);

      // Bounce: 3 low, 1 high, then 4 low. Only the final run may complete.
      switches = 18'h01234;
      request  = 1'b1;
      key0     = 1'b1;
      cyc(8);
      key0 = 1'b0;
      cyc(3);
      key0 = 1'b1;
      cyc(1);
      expect_word(sext(18'h01234));
      key0 = 1'b0;
      wait_done("bounce", 1'b1);
      request = 1'b0;
      key0    = 1'b1;
      cyc(1);

      // Back-to-back, with key0 held low across the first completion.
      switches = 18'h00055;
      request  = 1'b1;
      key0     = 1'b1;
      cyc(8);
      expect_word(sext(18'h00055));
      key0 = 1'b0;
      wait_done("b2b_first", 1'b1);
      cyc(12);
      check("b2b_held_stall", {31'd0, stall}, 32'd1);
      check("b2b_held_waiting", {31'd0, waiting}, 32'd1);
      switches = 18'h2AAAA;
      key0     = 1'b1;
      cyc(8);
      expect_word(sext(18'h2AAAA));
      key0 = 1'b0;
      wait_done("b2b_second", 1'b1);
      request = 1'b0;
      key0    = 1'b1;
      cyc(1);

      // Cancel reaches the FSM on the same cycle as the 4th low sample of key0.
      switches = 18'h3FFFF;
      request  = 1'b1;
      cyc(8);
      expect_word(32'd0);
      key0 = 1'b0;
      cyc(3);
      key1 = 1'b0;
      cyc(1);
      key1 = 1'b1;
      wait_done("cancel_prio", 1'b0);
      request = 1'b0;
      key0    = 1'b1;
      cyc(1);

      // Reset in PRESS after 2 low samples.
      press("pre_reset", 18'h00123, 1'b0, 0, 1'b0);
      request = 1'b1;
      cyc(8);
      key0 = 1'b0;
      cyc(4);
      reset = 1'b1;
      #1;
      check("abort_rst_dataOut", dataOut, 32'd0);
      check("abort_rst_done", {31'd0, done}, 32'd0);
      check("abort_rst_waiting", {31'd0, waiting}, 32'd0);
      check("abort_rst_stall", {31'd0, stall}, 32'd0);
      key0 = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(3);
      check("restart_waiting", {31'd0, waiting}, 32'd1);
      request = 1'b0;
      cyc(2);

      // Drop request while in ARM: no done, and dataOut keeps its value.
      press("pre_drop", 18'h1F0F0, 1'b0, 0, 1'b0);
      request = 1'b1;
      cyc(3);
      check("drop_arm_waiting", {31'd0, waiting}, 32'd1);
      request = 1'b0;
      cyc(4);
      check("drop_idle_waiting", {31'd0, waiting}, 32'd0);
      check("drop_dataOut", dataOut, sext(18'h1F0F0));

      // Randomized operator sequences.
      for (int t = 0; t < 12; t++) begin
         sw = 18'($urandom_range(0, 18'h3FFFF));
         press("rand", sw, ($urandom_range(0, 3) == 0), $urandom_range(0, 2),
               1'($urandom_range(0, 1)));
      end
      request = 1'b0;
      cyc(5);

      check("done_count", n_done, n_expected);
      check("queue_empty", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
